weighted_sum: RTL and testbench

WEIGHTED_SUM -- requirements
Module: weighted_sum

---
 rtl/perceptron_pkg.sv | 15 +
 rtl/q14_mult.sv | 31 +++
 rtl/weighted_sum.sv | 124 ++++++++++++
 tb/tb_weighted_sum.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared constants and FSM state type for the perceptron datapath.
// Operands are signed Q2.14, products Q4.28, and the accumulator is a wide Q.14 value.
package perceptron_pkg;
  localparam int ONESHIFT = 14;
  localparam int OP_W     = 16;
  localparam int PROD_W   = 2 * OP_W;
  localparam int ACC_W    = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/q14_mult.sv
// Registered 16x16 signed multiply.
// Output is the product floor-shifted back to Q.14 and sign-extended to accumulator width.
module q14_mult #(
  parameter int SHIFT = perceptron_pkg::ONESHIFT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      load,
  input  logic signed [perceptron_pkg::OP_W-1:0]    x_in,
  input  logic signed [perceptron_pkg::OP_W-1:0]    w_in,
  output logic signed [perceptron_pkg::ACC_W-1:0]   contrib
);
  import perceptron_pkg::*;

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  prod_ext;

  always_comb begin
    prod_d = prod_q;
    if (load) prod_d = x_in * w_in;
  end

  always_ff @(posedge clk) begin
    if (rst) prod_q <= '0;
    else     prod_q <= prod_d;
  end

  // Arithmetic shift after sign extension gives floor rounding for negatives.
  assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign contrib  = prod_ext >>> SHIFT;
endmodule

// File: rtl/weighted_sum.sv
// Streaming dot product: bias + sum of x*w contributions over one vector of beats.
// Each product is added one beat late, so a FLUSH cycle drains the final product.
module weighted_sum #(
  parameter int MAX_BEATS = 16,
  parameter int ONESHIFT  = perceptron_pkg::ONESHIFT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [15:0] x_in,
  input  logic [15:0] w_in,
  input  logic [15:0] bias,
  output logic [47:0] sum_out,
  output logic        sum_valid,
  output logic        overrun
);
  import perceptron_pkg::*;

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovr_pend_q, ovr_pend_d;
  logic [ACC_W-1:0]        sum_out_q, sum_out_d;
  logic                    sum_valid_q, sum_valid_d;
  logic                    overrun_q, overrun_d;

  logic                    accept;
  logic                    hit_max;
  logic signed [ACC_W-1:0] contrib;
  logic signed [ACC_W-1:0] bias_ext;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = in_valid && in_ready;
  assign hit_max  = (int'(cnt_q) + 1) >= MAX_BEATS;
  assign bias_ext = {{(ACC_W - OP_W){bias[OP_W-1]}}, bias};

  q14_mult #(
    .SHIFT (ONESHIFT)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .x_in    (x_in),
    .w_in    (w_in),
    .contrib (contrib)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovr_pend_d  = ovr_pend_q;
    sum_out_d   = sum_out_q;
    sum_valid_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        ovr_pend_d = 1'b0;
        if (accept) begin
          acc_d = bias_ext;
          cnt_d = cnt_q + 1'b1;
          if (in_last || hit_max) begin
            state_d    = FLUSH;
            ovr_pend_d = !in_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + contrib;
          cnt_d = cnt_q + 1'b1;
          if (in_last || hit_max) begin
            state_d    = FLUSH;
            ovr_pend_d = !in_last;
          end
        end
      end
      FLUSH: begin
        acc_d   = acc_q + contrib;
        state_d = OUT;
      end
      OUT: begin
        sum_out_d   = acc_q;
        sum_valid_d = 1'b1;
        overrun_d   = ovr_pend_q;
        cnt_d       = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovr_pend_q  <= 1'b0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovr_pend_q  <= ovr_pend_d;
      sum_out_q   <= sum_out_d;
      sum_valid_q <= sum_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sum_out   = sum_out_q;
  assign sum_valid = sum_valid_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_weighted_sum.sv
// Self-checking bench for weighted_sum: directed vectors with literal results
// plus a randomized beat stream checked every cycle against an arithmetic model.
module tb_weighted_sum;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] w_in = '0;
  logic [15:0] bias = '0;
  logic        in_ready;
  logic [47:0] sum_out;
  logic        sum_valid;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  weighted_sum #(.MAX_BEATS(MAXB), .ONESHIFT(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .x_in      (x_in),
    .w_in      (w_in),
    .bias      (bias),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%012h, expected 0x%012h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a vector is a list of accepted beats; its result is
  // bias + sum(floor(x*w / 2^14)) mod 2^48, visible two edges after the
  // final beat is accepted (sum_valid high after the third edge).
  int          edge_cnt = 0;
  bit          started = 0;
  int          n_beats = 0;
  longint      acc_m = 0;
  logic [47:0] pend_sum = '0;
  bit          pend_ovr = 0;
  logic [47:0] last_sum = '0;
  bit          last_ovr = 0;
  int          exp_at = -10;
  int          block = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      started  = 1;
      n_beats  = 0;
      exp_at   = -10;
      block    = 0;
      last_sum = '0;
      last_ovr = 0;
    end else begin
      if (edge_cnt == exp_at) begin
        last_sum = pend_sum;
        last_ovr = pend_ovr;
      end
      if (in_valid && block == 0) begin
        if (n_beats == 0) acc_m = longint'($signed(bias));
        acc_m += (longint'($signed(x_in)) * longint'($signed(w_in))) >>> 14;
        n_beats++;
        if (in_last || n_beats == MAXB) begin
          pend_sum = acc_m[47:0];
          pend_ovr = !in_last;
          exp_at   = edge_cnt + 2;
          block    = 2;
          n_beats  = 0;
        end
      end else if (block > 0) begin
        block--;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", {47'd0, in_ready}, {47'd0, (block == 0)});
      check("sum_valid", {47'd0, sum_valid}, {47'd0, (edge_cnt == exp_at)});
      check("overrun", {47'd0, overrun}, {47'd0, (edge_cnt == exp_at) && last_ovr});
      check("sum_out", sum_out, last_sum);
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b,
                      input bit last, input int gap);
    bit acc;
    int tries;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    x_in = x; w_in = w; bias = b; in_last = last;
    acc = 0;
    tries = 0;
    while (!acc && tries < 50) begin
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: beat never accepted, expected acceptance within 50 cycles");
    end
  endtask

  // Waits for the result pulse after the last beat; pins latency and value.
  task automatic expect_result(input string name, input logic [47:0] exp_sum, input bit exp_ovr);
    int k;
    bit seen;
    seen = 0;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sum_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no sum_valid within 12 cycles, expected one", name);
    end else begin
      check({name, "_latency"}, 48'(k), 48'd3);
      check({name, "_sum"}, sum_out, exp_sum);
      check({name, "_ovr"}, {47'd0, overrun}, {47'd0, exp_ovr});
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("ready_after_reset", {47'd0, in_ready}, 48'd1);
    check("sum_out_reset", sum_out, 48'd0);

    send(16'h4000, 16'h4000, 16'h0000, 1, 0);
    expect_result("one_beat", 48'h000000004000, 0);

    send(16'hC000, 16'h2000, 16'h1000, 0, 0);
    send(16'h4000, 16'h4000, 16'h1000, 1, 0);
    expect_result("two_beat_bias", 48'h000000003000, 0);

    send(16'h0001, 16'h0001, 16'h0000, 0, 0);
    send(16'hFFFF, 16'h0001, 16'h0000, 1, 0);
    expect_result("floor_trunc", 48'hFFFFFFFFFFFF, 0);

    for (int i = 0; i < MAXB; i++) send(16'h4000, 16'h4000, 16'h0000, 0, 0);
    expect_result("overrun16", 48'h000000040000, 1);

    for (int i = 0; i < MAXB; i++) send(16'h4000, 16'h4000, 16'h0000, i == MAXB - 1, 0);
    expect_result("last_on_16th", 48'h000000040000, 0);

    send(16'h4000, 16'h4000, 16'h0000, 0, 0);
    send(16'h4000, 16'h4000, 16'h0000, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(16'h2000, 16'h4000, 16'h0000, 1, 0);
    expect_result("after_reset", 48'h000000002000, 0);

    send(16'h4000, 16'h4000, 16'h0000, 0, 0);
    send(16'h2000, 16'h4000, 16'h0000, 0, 0);
    send(16'h1000, 16'h4000, 16'h0000, 1, 0);
    expect_result("no_gaps", 48'h000000007000, 0);
    send(16'h4000, 16'h4000, 16'h0000, 0, 1);
    send(16'h2000, 16'h4000, 16'h0000, 0, 1);
    send(16'h1000, 16'h4000, 16'h0000, 1, 1);
    expect_result("with_gaps", 48'h000000007000, 0);

    for (int i = 0; i < 150; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    send(16'($urandom), 16'($urandom), 16'($urandom), 1, 0);
    repeat (6) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
